// File: rtl/sram_pkg.sv
// Shared defaults and word/address types for the sync_sram register-file memory.
package sram_pkg;

  localparam int unsigned ADDRESS_BITS = 5;
  localparam int unsigned DATA_WIDTH   = 8;
  localparam int unsigned NUM_REG      = 32;

  typedef logic [ADDRESS_BITS-1:0] addr_t;
  typedef logic [DATA_WIDTH-1:0]   data_t;

endpackage

// File: rtl/sram_array.sv
// Storage for sync_sram: clocked write port, combinational address-indexed read
// that returns 0 for addresses at or beyond NUM_REG.
module sram_array #(
  parameter int unsigned ADDRESS_BITS = sram_pkg::ADDRESS_BITS,
  parameter int unsigned NUM_REG      = sram_pkg::NUM_REG,
  parameter int unsigned DATA_WIDTH   = sram_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [ADDRESS_BITS-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  output logic [DATA_WIDTH-1:0]   rd_word_o
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_REG];
  logic                  in_range;

  // Out-of-range addresses must never alias onto a real word.
  assign in_range = (32'(addr_i) < NUM_REG);

  // NOTE: the array is reset word-by-word because contents must be defined
  // after reset; this forbids mapping onto a RAM macro without reset support.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REG; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && in_range) begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      mem_q[addr_i] <= wr_data_i;
    end
  end

  assign rd_word_o = in_range ? mem_q[addr_i] : '0;

endmodule

// File: rtl/sync_sram.sv
// Single-port synchronous SRAM: control decode, read register, optional output
// gating. Define SRAM_TRISTATE_OUT_EN to float rd_data unless cs=1 and rd=0.
module sync_sram #(
  parameter int unsigned ADDRESS_BITS = sram_pkg::ADDRESS_BITS,
  parameter int unsigned NUM_REG      = sram_pkg::NUM_REG,
  parameter int unsigned DATA_WIDTH   = sram_pkg::DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs,
  input  logic                    we,
  input  logic                    rd,
  input  logic [ADDRESS_BITS-1:0] addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]   rd_data
);

  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] array_word;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write wins over the read strobe; a blocked read leaves rd_data untouched.
  assign write_en = cs & we;
  assign read_en  = cs & ~we & ~rd;

  sram_array #(
    .ADDRESS_BITS (ADDRESS_BITS),
    .NUM_REG      (NUM_REG),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_array (
    .clk       (clk),
    .rst_i     (rst),
    .we_i      (write_en),
    .addr_i    (addr),
    .wr_data_i (wr_data),
    .rd_word_o (array_word)
  );

  // NOTE: default assignment first so no path through this block infers a latch.
  always_comb begin
    rd_data_d = rd_data_q;
    if (read_en) begin
      rd_data_d = array_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

`ifdef SRAM_TRISTATE_OUT_EN
  assign rd_data = (cs && !rd) ? rd_data_q : 'z;
`else
  assign rd_data = rd_data_q;
`endif

endmodule

// File: tb/tb_sync_sram.sv
// Self-checking bench for sync_sram: directed test-plan steps followed by random
// traffic, all compared against an array-based reference model.
module tb_sync_sram;
  import sram_pkg::*;

  logic  clk = 1'b0;
  logic  rst, cs, we, rd;
  addr_t addr;
  data_t wr_data;
  data_t rd_data;

  int n_checks = 0;
  int n_errors = 0;

  data_t model [NUM_REG];
  data_t model_rd;

  sync_sram dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .rd      (rd),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data)
  );

  always #5 clk = ~clk;

  function automatic data_t expected_out();
`ifdef SRAM_TRISTATE_OUT_EN
    return (cs && !rd) ? model_rd : 'z;
`else
    return model_rd;
`endif
  endfunction

  task automatic check(input string tag, input data_t observed, input data_t expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the behavioural rules,
  // then compare rd_data just after the edge.
  task automatic op(input logic c, input logic w, input logic r, input logic rs,
                    input addr_t a, input data_t d, input string tag);
    rst = rs; cs = c; we = w; rd = r; addr = a; wr_data = d;
    if (rs) begin
      for (int i = 0; i < NUM_REG; i++) model[i] = '0;
      model_rd = '0;
    end else if (c && w) begin
      if (int'(a) < NUM_REG) model[a] = d;
    end else if (c && !r) begin
      model_rd = (int'(a) < NUM_REG) ? model[a] : '0;
    end
    @(posedge clk);
    #1;
    check(tag, rd_data, expected_out());
  endtask

  task automatic rd_op(input addr_t a, input string tag);
    op(1'b1, 1'b0, 1'b0, 1'b0, a, $urandom(), tag);
  endtask

  task automatic wr_op(input addr_t a, input data_t d, input string tag);
    op(1'b1, 1'b1, 1'b1, 1'b0, a, d, tag);
  endtask

  initial begin
    data_t prior;
    rst = 1'b1; cs = 1'b0; we = 1'b0; rd = 1'b1; addr = '0; wr_data = '0;
    for (int i = 0; i < NUM_REG; i++) model[i] = 'x;
    model_rd = 'x;

    // Reset for two cycles, reset overriding an active write request.
    op(1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 8'h77, "reset_0");
    op(1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 8'h00, "reset_1");
    check("reset_value", rd_data, 8'h00);
    rd_op(5'd0,  "reset_rd0");
    rd_op(5'd15, "reset_rd15");
    rd_op(5'd31, "reset_rd31");
    check("reset_rd31_zero", rd_data, 8'h00);

    // Fill with 3k, then read back from the top.
    for (int k = 0; k < NUM_REG; k++) wr_op(addr_t'(k), data_t'(3 * k), "fill");
    for (int k = NUM_REG - 1; k >= 0; k--) begin
      rd_op(addr_t'(k), "readback");
      if (k == 31) check("readback_31_const", rd_data, 8'b0101_1101);
      if (k == 1)  check("readback_1_const", rd_data, 8'h03);
    end
    check("readback_0_const", rd_data, 8'h00);

    // Deselected write is ignored; rd_data holds while cs=0.
    rd_op(5'd9, "pre_deselect");
    prior = rd_data;
    op(1'b0, 1'b1, 1'b0, 1'b0, 5'd4, 8'hFF, "deselect_wr");
    check("deselect_hold", rd_data, prior);
    op(1'b0, 1'b0, 1'b0, 1'b0, 5'd4, 8'h00, "deselect_rd");
    check("deselect_hold2", rd_data, prior);
    rd_op(5'd4, "deselect_readback");
    check("deselect_readback_const", rd_data, 8'h0C);

    // Write priority over a simultaneous read strobe.
    prior = rd_data;
    op(1'b1, 1'b1, 1'b0, 1'b0, 5'd7, 8'hA5, "wr_priority");
    check("wr_priority_hold", rd_data, prior);
    rd_op(5'd7, "wr_priority_rd");
    check("wr_priority_rd_const", rd_data, 8'hA5);

    // Idle with we=0, rd=1 holds.
    op(1'b1, 1'b0, 1'b1, 1'b0, 5'd2, 8'h00, "idle_hold");

    // Reset in the middle of a read sweep, with a read also requested.
    for (int k = NUM_REG - 1; k > 20; k--) rd_op(addr_t'(k), "sweep");
    op(1'b1, 1'b0, 1'b0, 1'b1, 5'd20, 8'h00, "mid_reset");
    check("mid_reset_zero", rd_data, 8'h00);
    for (int k = 0; k < NUM_REG; k++) rd_op(addr_t'(k), "post_reset_rd");

`ifdef SRAM_TRISTATE_OUT_EN
    op(1'b1, 1'b1, 1'b1, 1'b0, 5'd5, 8'h3C, "tri_wr");
    rd_op(5'd5, "tri_rd");
    op(1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 8'h00, "tri_float");
    check("tri_float_z", rd_data, 8'hzz);
    op(1'b1, 1'b1, 1'b1, 1'b0, 5'd6, 8'h11, "tri_wr2");
    cs = 1'b1; rd = 1'b0; we = 1'b0; #1;
    check("tri_drive", rd_data, 8'h3C);
`endif

    // Random traffic with occasional resets.
    for (int n = 0; n < 400; n++) begin
      op($urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
         $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0,
         addr_t'($urandom()), data_t'($urandom()), "random");
    end
    for (int k = 0; k < NUM_REG; k++) rd_op(addr_t'(k), "final_readback");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
